fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameters: none; register index width fixed at 5, X31 (XZR) reads as zero and is never a forwarding source.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 id_rn, id_rm  input  5 each  decode-stage source register indices.
REQ-006 id_rd  input  5  decode-stage destination register index.
REQ-007 id_regwrite  input  1  decode instruction writes id_rd.
REQ-008 id_memread  input  1  decode instruction is a load.
REQ-009 flush  input  1  kill decode instruction (branch taken).
REQ-010 stall_ext  input  1  global freeze (memory wait).
REQ-011 fwd_a, fwd_b  output  2 each  EX operand A/B select for the 4:1 operand mux: 00 register file, 01 MEM-stage result, 10 WB-stage result, 11 constant zero.
REQ-012 stall_lu  output  1  load-use hazard; decode and fetch must hold.
REQ-013 ex_valid  output  1  EX stage holds a real instruction.

Function
REQ-014 Block SHALL hold shadow pipeline registers: EX {valid, rn, rm, rd, regwrite, memread}, MEM {valid, rd, regwrite}, WB {valid, rd, regwrite}.
REQ-015 Normal advance (stall_ext=0, stall_lu=0, flush=0): ID fields -> EX, EX -> MEM, MEM -> WB each rising edge; latency ID to fwd_a/fwd_b valid = 1 cycle.
REQ-016 stall_ext=1: all shadow registers hold; outputs stay stable; overrides stall_lu and flush.
REQ-017 stall_lu SHALL be combinational: ex_valid & ex_memread & ex_regwrite & ex_rd!=31 & id_valid & (id_rn==ex_rd | id_rm==ex_rd).
REQ-018 stall_lu=1 (stall_ext=0): EX loads bubble (valid=0, regwrite=0, memread=0); EX -> MEM and MEM -> WB still advance; ID fields not captured.
REQ-019 flush=1 (stall_ext=0): EX loads bubble; MEM/WB advance; flush and stall_lu together -> single bubble, flush wins.
REQ-020 fwd_a SHALL be 11 when ex_rn==31, regardless of hazards.
REQ-021 Else fwd_a SHALL be 01 when mem_valid & mem_regwrite & mem_rd!=31 & mem_rd==ex_rn.
REQ-022 Else fwd_a SHALL be 10 when wb_valid & wb_regwrite & wb_rd!=31 & wb_rd==ex_rn.
REQ-023 Else fwd_a SHALL be 00; MEM priority over WB when both match (youngest wins).
REQ-024 fwd_b SHALL follow REQ-020..023 using ex_rm.
REQ-025 fwd_a/fwd_b SHALL be decoded combinationally from shadow registers only, no input-to-output path; when ex_valid=0 outputs SHALL be 00.
REQ-026 Instructions with regwrite=0 (stores, branches) SHALL never be forwarding sources, even with valid rd field.

Reset
REQ-027 rst_n low SHALL immediately clear all valid, regwrite, memread bits and all index fields to 0, independent of clk.
REQ-028 During and after reset until the first valid advance: fwd_a=00, fwd_b=00, stall_lu=0, ex_valid=0.
REQ-029 Reset mid-operation SHALL discard all in-flight instructions; no forwarding from pre-reset state.

Verification
REQ-030 Back-to-back ALU: ADD X1 (rd=1,regwrite) then SUB rn=1,rm=2 -> cycle SUB is in EX: fwd_a=01, fwd_b=00.
REQ-031 Distance-2 plus double match: writers rd=3 then rd=3 then reader rn=3,rm=3 -> fwd_a=fwd_b=01 (MEM wins); with one unrelated instruction between single writer and reader -> 10.
REQ-032 Load-use: LDUR rd=5 then ADD rn=5 -> stall_lu=1 one cycle, ex_valid=0 next cycle, then ADD in EX with fwd_a=10.
REQ-033 XZR: writer rd=31 then reader rn=31,rm=31 -> fwd_a=fwd_b=11, stall_lu=0 even if writer is a load.
REQ-034 stall_ext held 3 cycles with writer in MEM -> fwd outputs constant 01 all 3 cycles; flush asserted together with stall_lu -> exactly one bubble, no duplicate ADD.
REQ-035 rst_n pulsed low mid-stream between clk edges -> outputs 00/0 immediately; next reader of previously-written register -> fwd 00.

Source files
------------

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Shadows EX/MEM/WB register-write info and decodes the EX operand mux selects.
module fwd_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       flush,
    input  logic       stall_ext,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall_lu,
    output logic       ex_valid
);

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    logic       r_ex_valid;
    logic [4:0] r_ex_rn;
    logic [4:0] r_ex_rm;
    logic [4:0] r_ex_rd;
    logic       r_ex_regwrite;
    logic       r_ex_memread;

    logic       r_mem_valid;
    logic [4:0] r_mem_rd;
    logic       r_mem_regwrite;

    logic       r_wb_valid;
    logic [4:0] r_wb_rd;
    logic       r_wb_regwrite;

    logic       w_stall_lu;
    logic       w_bubble;

    // XZR wins over any hazard; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic       ex_vld,
        input logic [4:0] src,
        input logic       mem_vld,
        input logic       mem_rw,
        input logic [4:0] mem_rd,
        input logic       wb_vld,
        input logic       wb_rw,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!ex_vld)
            sel = SEL_RF;
        else if (src == XZR)
            sel = SEL_ZERO;
        else if (mem_vld && mem_rw && (mem_rd != XZR) && (mem_rd == src))
            sel = SEL_MEM;
        else if (wb_vld && wb_rw && (wb_rd != XZR) && (wb_rd == src))
            sel = SEL_WB;
        return sel;
    endfunction

    assign w_stall_lu = r_ex_valid && r_ex_memread && r_ex_regwrite && (r_ex_rd != XZR) &&
                        id_valid && ((id_rn == r_ex_rd) || (id_rm == r_ex_rd));
    assign w_bubble   = flush || w_stall_lu;

    assign stall_lu = w_stall_lu;
    assign ex_valid = r_ex_valid;

    assign fwd_a = fwd_sel(r_ex_valid, r_ex_rn, r_mem_valid, r_mem_regwrite, r_mem_rd,
                           r_wb_valid, r_wb_regwrite, r_wb_rd);
    assign fwd_b = fwd_sel(r_ex_valid, r_ex_rm, r_mem_valid, r_mem_regwrite, r_mem_rd,
                           r_wb_valid, r_wb_regwrite, r_wb_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rn        <= 5'd0;
            r_ex_rm        <= 5'd0;
            r_ex_rd        <= 5'd0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= 5'd0;
            r_mem_regwrite <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_regwrite  <= 1'b0;
        end else if (!stall_ext) begin
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            // A bubble keeps the stale EX indices; they are masked by valid=0.
            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_valid    <= id_valid;
                r_ex_rn       <= id_rn;
                r_ex_rm       <= id_rm;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: one task per scenario, inline expected-value checks.
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall_ext;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_lu;
    logic       ex_valid;

    int tests;
    int errors;

    fwd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .stall_ext  (stall_ext),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_lu   (stall_lu),
        .ex_valid   (ex_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rn       = rn;
        id_rm       = rm;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        stall_ext = 1'b0;
        issue(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
        #12;
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", fwd_b); end
        tests++; if (stall_lu !== 1'b0) begin errors++; $display("FAIL reset_stall_lu: got %b expected 0", stall_lu); end
        tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 5'd4, 5'd5, 5'd1, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL b2b_first_fwd_a: got %b expected 00", fwd_a); end
        issue(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);
        tick();
        tests++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL b2b_ex_valid: got %b expected 1", ex_valid); end
        tests++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a: got %b expected 01", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL b2b_fwd_b: got %b expected 00", fwd_b); end
        drain();
    endtask

    task automatic test_distance2();
        issue(1'b1, 5'd7, 5'd8, 5'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd7, 5'd8, 5'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL dbl_fwd_a: got %b expected 01", fwd_a); end
        tests++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL dbl_fwd_b: got %b expected 01", fwd_b); end
        drain();
        issue(1'b1, 5'd7, 5'd8, 5'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd11, 5'd12, 5'd10, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 5'd2, 5'd9, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL dist2_fwd_a: got %b expected 10", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL dist2_fwd_b: got %b expected 00", fwd_b); end
        drain();
    endtask

    task automatic test_no_regwrite();
        issue(1'b1, 5'd7, 5'd8, 5'd4, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd4, 5'd4, 5'd9, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL store_fwd_a: got %b expected 00", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL store_fwd_b: got %b expected 00", fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        issue(1'b1, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0);
        #1;
        tests++; if (stall_lu !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall_lu); end
        tick();
        tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_ex_valid: got %b expected 0", ex_valid); end
        tests++; if (stall_lu !== 1'b0) begin errors++; $display("FAIL lu_stall_release: got %b expected 0", stall_lu); end
        tick();
        tests++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_ex_valid: got %b expected 1", ex_valid); end
        tests++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b expected 10", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b expected 00", fwd_b); end
        drain();
    endtask

    task automatic test_xzr();
        issue(1'b1, 5'd6, 5'd0, 5'd31, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd31, 5'd31, 5'd9, 1'b1, 1'b0);
        #1;
        tests++; if (stall_lu !== 1'b0) begin errors++; $display("FAIL xzr_stall: got %b expected 0", stall_lu); end
        tick();
        tests++; if (fwd_a !== 2'b11) begin errors++; $display("FAIL xzr_fwd_a: got %b expected 11", fwd_a); end
        tests++; if (fwd_b !== 2'b11) begin errors++; $display("FAIL xzr_fwd_b: got %b expected 11", fwd_b); end
        drain();
    endtask

    task automatic test_stall_ext();
        issue(1'b1, 5'd7, 5'd8, 5'd13, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd13, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL sx_pre_fwd_a: got %b expected 01", fwd_a); end
        stall_ext = 1'b1;
        issue(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL sx_hold_fwd_a[%0d]: got %b expected 01", i, fwd_a); end
            tests++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sx_hold_ex_valid[%0d]: got %b expected 1", i, ex_valid); end
        end
        stall_ext = 1'b0;
        idle();
        tick();
        tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL sx_release_ex_valid: got %b expected 0", ex_valid); end
        drain();
    endtask

    task automatic test_flush_lu();
        issue(1'b1, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tests++; if (stall_lu !== 1'b1) begin errors++; $display("FAIL fl_stall: got %b expected 1", stall_lu); end
        tick();
        flush = 1'b0;
        issue(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0);
        #1;
        tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_bubble_ex_valid: got %b expected 0", ex_valid); end
        tests++; if (stall_lu !== 1'b0) begin errors++; $display("FAIL fl_bubble_stall: got %b expected 0", stall_lu); end
        tick();
        tests++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fl_next_ex_valid: got %b expected 1", ex_valid); end
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fl_next_fwd_a: got %b expected 00", fwd_a); end
        drain();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 5'd7, 5'd8, 5'd14, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0);
        tick();
        tests++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL rm_pre_fwd_a: got %b expected 01", fwd_a); end
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL rm_fwd_a: got %b expected 00", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL rm_fwd_b: got %b expected 00", fwd_b); end
        tests++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rm_ex_valid: got %b expected 0", ex_valid); end
        tests++; if (stall_lu !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b expected 0", stall_lu); end
        #2;
        rst_n = 1'b1;
        issue(1'b1, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0);
        tick();
        tests++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rm_after_ex_valid: got %b expected 1", ex_valid); end
        tests++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL rm_after_fwd_a: got %b expected 00", fwd_a); end
        tests++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL rm_after_fwd_b: got %b expected 00", fwd_b); end
        drain();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_distance2();
        test_no_regwrite();
        test_load_use();
        test_xzr();
        test_stall_ext();
        test_flush_lu();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
